cache_arbiter: RTL and testbench

Arbiter that shares the single physical-memory line port between the instruction cache and the data cache in the pipelined RV32I core. It sits between both caches' miss/writeback interfaces and the cacheline adaptor. It grants one requester at a time, forwards that requester's line read or write to physical memory, and routes the response back to it. A short turnaround state after each transfer ensures a stale request is never re-granted.

---
 rtl/cache_arbiter_pkg.sv | 15 +
 rtl/cache_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    arb_idle   = 2'b00,
    arb_icache = 2'b01,
    arb_dcache = 2'b10,
    arb_done   = 2'b11
  } arbiter_states;

  // Encoding of the last_served flag used by round-robin tie breaking.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the physical-memory line port between I-cache and D-cache.
// Define CACHE_ARBITER_RR_EN for round-robin ties; default build lets the D-cache win ties.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arbiter_states r_state;
  arbiter_states w_state_next;

  logic w_i_req;
  logic w_d_req;
  logic w_tie_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
  logic r_last_served;
  logic w_resp_i;
  logic w_resp_d;

  assign w_resp_i = (r_state == arb_icache) && pmem_resp;
  assign w_resp_d = (r_state == arb_dcache) && pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_served <= REQ_I;
    end else if (w_resp_i) begin
      r_last_served <= REQ_I;
    end else if (w_resp_d) begin
      r_last_served <= REQ_D;
    end
  end

  // The requester that was not served last wins a tie.
  assign w_tie_d = (r_last_served == REQ_I);
`else
  assign w_tie_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= arb_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      arb_idle: begin
        if (w_i_req && w_d_req) begin
          w_state_next = w_tie_d ? arb_dcache : arb_icache;
        end else if (w_i_req) begin
          w_state_next = arb_icache;
        end else if (w_d_req) begin
          w_state_next = arb_dcache;
        end
      end
      arb_icache: begin
        if (pmem_resp) w_state_next = arb_done;
      end
      arb_dcache: begin
        if (pmem_resp) w_state_next = arb_done;
      end
      // One dead cycle lets the served requester drop its request before idle re-samples it.
      arb_done: w_state_next = arb_idle;
      default:  w_state_next = arb_idle;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    unique case (r_state)
      arb_icache: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
        end
      end
      arb_dcache: begin
        // A write wins if both strobes are (illegally) raised together.
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic vs. a model.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: who currently owns memory (0 none, 1 I, 2 D) and whether we are in the
  // mandatory gap cycle after a transfer. Evaluated on the falling edge, inputs are stable then.
  int m_owner = 0;
  bit m_gap = 1'b0;
  bit m_last_d = 1'b0;

  always @(negedge clk) begin
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_irdata, e_drdata;
    bit            want_i, want_d;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
    if (d_read && d_write) $display("note: illegal d_read+d_write at %0t", $time);
    if (!m_gap && m_owner == 1) begin
      e_rd = 1'b1;
      e_addr = i_address;
      e_ir = pmem_resp;
      if (pmem_resp) e_irdata = pmem_rdata;
    end else if (!m_gap && m_owner == 2) begin
      e_wr = d_write;
      e_rd = d_read && !d_write;
      e_addr = d_address;
      e_wdata = d_wdata;
      e_dr = pmem_resp;
      if (pmem_resp) e_drdata = pmem_rdata;
    end
    chk("m_pmem_read", pmem_read, e_rd);
    chk("m_pmem_write", pmem_write, e_wr);
    chk("m_pmem_address", pmem_address, e_addr);
    chk("m_pmem_wdata", pmem_wdata, e_wdata);
    chk("m_i_resp", i_resp, e_ir);
    chk("m_i_rdata", i_rdata, e_irdata);
    chk("m_d_resp", d_resp, e_dr);
    chk("m_d_rdata", d_rdata, e_drdata);
    want_i = i_read;
    want_d = d_read || d_write;
    if (rst) begin
      m_owner = 0; m_gap = 1'b0; m_last_d = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner == 0) begin
      if (want_i && want_d) begin
`ifdef CACHE_ARBITER_RR_EN
        m_owner = m_last_d ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (want_i) m_owner = 1;
      else if (want_d) m_owner = 2;
    end else if (pmem_resp) begin
      m_last_d = (m_owner == 2);
      m_owner = 0;
      m_gap = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic random_phase(input int n);
    bit i_pend = 1'b0, d_pend = 1'b0, i_got = 1'b0, d_got = 1'b0, busy, op;
    int cnt = 0, lat = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      busy = pmem_read | pmem_write;
      #1;
      if (i_got && $urandom_range(1, 0) == 0) begin
        i_read = 1'b0; i_pend = 1'b0;
      end else if (!i_pend && $urandom_range(3, 0) == 0) begin
        i_read = 1'b1; i_address = $urandom; i_pend = 1'b1;
      end
      if (d_got && $urandom_range(1, 0) == 0) begin
        d_read = 1'b0; d_write = 1'b0; d_pend = 1'b0;
      end else if (!d_pend && $urandom_range(3, 0) == 0) begin
        op = $urandom_range(1, 0);
        d_read = op; d_write = !op; d_address = $urandom; d_wdata = rand_line();
        d_pend = 1'b1;
      end
      if (busy) begin
        if (cnt == 0) lat = $urandom_range(4, 0);
        if (cnt >= lat) begin
          pmem_resp = 1'b1; cnt = 0;
        end else begin
          pmem_resp = 1'b0; cnt++;
        end
      end else begin
        pmem_resp = ($urandom_range(9, 0) == 0);
        cnt = 0;
      end
      pmem_rdata = rand_line();
      rst = ($urandom_range(199, 0) == 0);
      #1;
      i_got = i_resp;
      d_got = d_resp;
    end
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] a5, wd, rd;
    logic [AW-1:0] win_addr;
    bit            win_d;
    a5 = {32{8'hA5}};
    wd = {8{32'h1234_5678}};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, '0);
    chk("rst_i_resp", i_resp, 1'b0);
    chk("rst_d_resp", d_resp, 1'b0);

    // I-only fill, memory answers in the fifth strobe cycle
    tick();
    i_read = 1'b1; i_address = 32'h0000_0040;
    for (int c = 1; c <= 5; c++) begin
      tick();
      pmem_resp = (c == 5); pmem_rdata = a5;
      #1;
      chk("ionly_pmem_read", pmem_read, 1'b1);
      chk("ionly_pmem_address", pmem_address, 32'h40);
      chk("ionly_i_resp", i_resp, (c == 5));
      chk("ionly_d_resp", d_resp, 1'b0);
      if (c == 5) chk("ionly_i_rdata", i_rdata, a5);
    end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    chk("ionly_done_read", pmem_read, 1'b0);
    tick();

    // D writeback, response in third strobe cycle
    d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = wd;
    for (int c = 1; c <= 3; c++) begin
      tick();
      pmem_resp = (c == 3);
      #1;
      chk("dwb_pmem_write", pmem_write, 1'b1);
      chk("dwb_pmem_read", pmem_read, 1'b0);
      chk("dwb_pmem_address", pmem_address, 32'h8000_0020);
      chk("dwb_pmem_wdata", pmem_wdata, wd);
      chk("dwb_d_resp", d_resp, (c == 3));
      chk("dwb_i_resp", i_resp, 1'b0);
    end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    #1;
    chk("dwb_done_write", pmem_write, 1'b0);

    // Ties: both requests held continuously; winners D,D,D fixed or D,I,D round-robin
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    for (int r = 0; r < 3; r++) begin
`ifdef CACHE_ARBITER_RR_EN
      win_d = (r != 1);
`else
      win_d = 1'b1;
`endif
      win_addr = win_d ? 32'h200 : 32'h100;
      rd = rand_line();
      tick();
      pmem_resp = 1'b1; pmem_rdata = rd;
      #1;
      chk("tie_pmem_read", pmem_read, 1'b1);
      chk("tie_pmem_address", pmem_address, win_addr);
      chk("tie_i_resp", i_resp, !win_d);
      chk("tie_d_resp", d_resp, win_d);
      tick();
      pmem_resp = 1'b0;
      if (r == 2) d_read = 1'b0;
      #1;
      chk("tie_stale_done", pmem_read, 1'b0);
      tick();
      #1;
      chk("tie_stale_idle", pmem_read, 1'b0);
    end
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("tie_late_i_address", pmem_address, 32'h100);
    chk("tie_late_i_resp", i_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    tick();

    // Reset in the middle of a D transfer, then a late response
    d_read = 1'b1; d_address = 32'h300;
    tick();
    #1;
    chk("rmid_grant_read", pmem_read, 1'b1);
    chk("rmid_grant_address", pmem_address, 32'h300);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_read = 1'b0; pmem_resp = 1'b1;
    #1;
    chk("rmid_after_read", pmem_read, 1'b0);
    chk("rmid_after_write", pmem_write, 1'b0);
    chk("rmid_late_d_resp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b0; i_read = 1'b1; i_address = 32'h440;
    #1;
    chk("rmid_idle_read", pmem_read, 1'b0);
    rd = rand_line();
    tick();
    pmem_resp = 1'b1; pmem_rdata = rd;
    #1;
    chk("rmid_i_read", pmem_read, 1'b1);
    chk("rmid_i_address", pmem_address, 32'h440);
    chk("rmid_i_rdata", i_rdata, rd);
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    tick();

    random_phase(3000);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
